// File: rtl/nios2_oci_dct_capture.sv
// Debug-capture-trace collector: buffers {dct_count, dct_buffer} samples in a
// circular store during a run, then drains them oldest-first once test_ending arrives.
module nios2_oci_dct_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 1,
  parameter int OVF_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dct_valid,
  input  logic [DATA_W-1:0]        dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic [OVF_W-1:0]         overflow_cnt,
  output logic                     test_has_ended
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LEVEL  = LVL_W'(1);

  typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

  state_t                    state, state_next;
  logic [CNT_W+DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic                      full, accept, do_write, grow, pop;

  // A sample counts only in CAPTURE and only if it carries at least one unit.
  assign full      = (level == FULL_LEVEL);
  assign accept    = (state == CAPTURE) && dct_valid && (dct_count != '0);
  assign do_write  = accept && (!full || (WRAP_MODE != 0));
  assign grow      = accept && !full;
  assign out_valid = (state == DRAIN) && (level != '0);
  assign pop       = out_valid && out_ready;

  assign {out_count, out_data} = mem[rd_ptr];
  assign test_has_ended        = (state == DONE);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {dct_count, dct_buffer};
  end

  // Overwriting a full buffer pushes the read pointer along so the oldest entry is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (do_write && full)) rd_ptr <= rd_ptr + 1'b1;
      if (grow) level <= level + 1'b1;
      else if (pop) level <= level - 1'b1;
      if (accept && full && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CAPTURE;
    else       state <= state_next;
  end

  // The end-of-test decision must include a sample written in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      CAPTURE: if (test_ending) state_next = ((level != '0) || grow) ? DRAIN : DONE;
      DRAIN:   if (pop && (level == ONE_LEVEL)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = CAPTURE;
    endcase
  end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Bench for nios2_oci_dct_capture: a wrap-mode and a drop-mode instance share stimulus
// and are compared against queue-based reference models of the capture/drain behaviour.
module tb_nios2_oci_dct_capture;
  localparam int DW = 30;
  localparam int CW = 4;
  localparam int D  = 4;
  localparam int CAP_PH = 0, DRAIN_PH = 1, DONE_PH = 2;

  typedef logic [CW+DW-1:0] ent_t;

  logic clk = 1'b0;
  logic reset, dct_valid, test_ending, out_ready;
  logic [DW-1:0] dct_buffer;
  logic [CW-1:0] dct_count;
  logic [1:0] ov, the;
  logic [1:0][DW-1:0] od;
  logic [1:0][CW-1:0] oc;
  logic [1:0][2:0] lv;
  logic [15:0] ovf0;
  logic [1:0]  ovf1;

  ent_t mq [2][$];
  int   mphase [2];
  int   movf [2];
  int   ovf_max [2] = '{65535, 3};
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  nios2_oci_dct_capture #(.DATA_W(DW), .CNT_W(CW), .DEPTH(D), .WRAP_MODE(1), .OVF_W(16)) dut_wrap (
    .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_count(oc[0]), .level(lv[0]), .overflow_cnt(ovf0), .test_has_ended(the[0]));

  nios2_oci_dct_capture #(.DATA_W(DW), .CNT_W(CW), .DEPTH(D), .WRAP_MODE(0), .OVF_W(2)) dut_drop (
    .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_count(oc[1]), .level(lv[1]), .overflow_cnt(ovf1), .test_has_ended(the[1]));

  function automatic int get_ovf(int m);
    return (m == 0) ? int'(ovf0) : int'(ovf1);
  endfunction

  // Reference behaviour: a bounded queue per instance plus a run/drain/done phase.
  task automatic model_edge(input logic v, input logic [DW-1:0] b, input logic [CW-1:0] c,
                            input logic te, input logic rdy);
    for (int m = 0; m < 2; m++) begin
      case (mphase[m])
        CAP_PH: begin
          if (v && c != 0) begin
            if (mq[m].size() < D) mq[m].push_back({c, b});
            else begin
              if (m == 0) begin
                void'(mq[m].pop_front());
                mq[m].push_back({c, b});
              end
              if (movf[m] < ovf_max[m]) movf[m]++;
            end
          end
          if (te) mphase[m] = (mq[m].size() > 0) ? DRAIN_PH : DONE_PH;
        end
        DRAIN_PH: begin
          if (rdy) begin
            void'(mq[m].pop_front());
            if (mq[m].size() == 0) mphase[m] = DONE_PH;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle's inputs from a falling edge and return at the next falling edge.
  task automatic step(input logic v, input logic [DW-1:0] b, input logic [CW-1:0] c,
                      input logic te, input logic rdy);
    dct_valid = v; dct_buffer = b; dct_count = c; test_ending = te; out_ready = rdy;
    @(posedge clk);
    model_edge(v, b, c, te, rdy);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mphase[m] = CAP_PH;
      movf[m] = 0;
    end
  endtask

  task automatic do_reset();
    dct_valid = 0; dct_buffer = '0; dct_count = '0; test_ending = 0; out_ready = 0;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    dct_valid = 0; dct_buffer = '0; dct_count = '0; test_ending = 0; out_ready = 0;
    reset = 1'b1;
    model_clear();
    #2;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b0 || the[m] !== 1'b0 || lv[m] !== 3'd0 || get_ovf(m) !== 0)
        $display("[TB] FAIL reset inst%0d: got v=%b ended=%b lvl=%0d ovf=%0d, expected all 0",
                 m, ov[m], the[m], lv[m], get_ovf(m));
      else passed++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 1; i <= 3; i++) step(1, DW'(i), 4'd1, 0, 1);
    step(0, '0, '0, 1, 1);
    for (int i = 1; i <= 3; i++) begin
      for (int m = 0; m < 2; m++) begin
        total++;
        if (ov[m] !== 1'b1 || od[m] !== DW'(i) || oc[m] !== 4'd1)
          $display("[TB] FAIL in_order inst%0d entry%0d: got v=%b d=%0h c=%0h, expected v=1 d=%0h c=1",
                   m, i, ov[m], od[m], oc[m], i);
        else passed++;
      end
      step(0, '0, '0, 0, 1);
    end
    for (int m = 0; m < 2; m++) begin
      total++;
      if (the[m] !== 1'b1 || lv[m] !== 3'd0 || get_ovf(m) !== 0 || ov[m] !== 1'b0)
        $display("[TB] FAIL in_order_end inst%0d: got ended=%b lvl=%0d ovf=%0d v=%b, expected 1/0/0/0",
                 m, the[m], lv[m], get_ovf(m), ov[m]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    int exp_d;
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, DW'(i), 4'd1, 0, 0);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (lv[m] !== 3'd4 || get_ovf(m) !== 2)
        $display("[TB] FAIL overflow_level inst%0d: got lvl=%0d ovf=%0d, expected lvl=4 ovf=2",
                 m, lv[m], get_ovf(m));
      else passed++;
    end
    step(1, DW'(7), 4'd1, 0, 0);
    step(1, DW'(8), 4'd1, 0, 0);
    total++;
    if (ovf0 !== 16'd4 || ovf1 !== 2'd3)
      $display("[TB] FAIL overflow_sat: got wrap=%0d drop=%0d, expected wrap=4 drop=3", ovf0, ovf1);
    else passed++;
    step(0, '0, '0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++) begin
        exp_d = (m == 0) ? 5 + k : 1 + k;
        total++;
        if (ov[m] !== 1'b1 || od[m] !== DW'(exp_d))
          $display("[TB] FAIL overflow_drain inst%0d slot%0d: got v=%b d=%0h, expected v=1 d=%0h",
                   m, k, ov[m], od[m], exp_d);
        else passed++;
      end
      step(0, '0, '0, 0, 1);
    end
    total++;
    if (the !== 2'b11 || ovf0 !== 16'd4 || ovf1 !== 2'd3)
      $display("[TB] FAIL overflow_end: got ended=%b ovf=%0d/%0d, expected 11 and 4/3", the, ovf0, ovf1);
    else passed++;
  endtask

  task automatic test_count_zero_stall();
    ent_t exp_q [$];
    logic rdy_pat [6] = '{1, 0, 0, 1, 1, 1};
    int idx = 0;
    do_reset();
    step(1, DW'('h11), 4'd2, 0, 0);
    step(1, DW'('hAA), 4'd0, 0, 0);
    step(1, DW'('h22), 4'd1, 0, 0);
    step(1, DW'('hAA), 4'd0, 0, 0);
    total++;
    if (lv[0] !== 3'd2)
      $display("[TB] FAIL count_zero_level: got %0d, expected 2", lv[0]);
    else passed++;
    step(1, DW'(7), 4'd3, 1, 1);
    exp_q = '{{4'd2, DW'('h11)}, {4'd1, DW'('h22)}, {4'd3, DW'(7)}};
    for (int s = 0; s < 6 && idx < 3; s++) begin
      total++;
      if (ov[0] !== 1'b1 || {oc[0], od[0]} !== exp_q[idx])
        $display("[TB] FAIL stall_drain step%0d: got v=%b c=%0h d=%0h, expected v=1 entry=%0h",
                 s, ov[0], oc[0], od[0], exp_q[idx]);
      else passed++;
      step(0, '0, '0, 0, rdy_pat[s]);
      if (rdy_pat[s]) idx++;
    end
    total++;
    if (the[0] !== 1'b1 || lv[0] !== 3'd0)
      $display("[TB] FAIL stall_end: got ended=%b lvl=%0d, expected 1/0", the[0], lv[0]);
    else passed++;
  endtask

  task automatic test_empty_end();
    do_reset();
    step(0, '0, '0, 1, 1);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b0 || the[m] !== 1'b1)
        $display("[TB] FAIL empty_end inst%0d: got v=%b ended=%b, expected v=0 ended=1", m, ov[m], the[m]);
      else passed++;
    end
    step(1, DW'(5), 4'd1, 0, 1);
    step(1, DW'(6), 4'd2, 1, 1);
    total++;
    if (lv !== '0 || the !== 2'b11 || ov !== 2'b00 || ovf0 !== 16'd0)
      $display("[TB] FAIL empty_after: got lvl=%0d/%0d ended=%b v=%b ovf=%0d, expected 0/0 11 00 0",
               lv[0], lv[1], the, ov, ovf0);
    else passed++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, DW'(i), 4'd1, 0, 0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 0, 1);
    step(0, '0, '0, 0, 1);
    total++;
    if (ov[0] !== 1'b1 || od[0] !== DW'(3) || lv[0] !== 3'd2)
      $display("[TB] FAIL mid_drain: got v=%b d=%0h lvl=%0d, expected v=1 d=3 lvl=2", ov[0], od[0], lv[0]);
    else passed++;
    reset = 1'b1;
    model_clear();
    #1;
    total++;
    if (ov !== 2'b00 || lv !== '0 || the !== 2'b00)
      $display("[TB] FAIL async_reset: got v=%b lvl=%0d/%0d ended=%b, expected all 0", ov, lv[0], lv[1], the);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    step(1, DW'(9), 4'd1, 0, 0);
    step(0, '0, '0, 1, 0);
    total++;
    if (ov[0] !== 1'b1 || od[0] !== DW'(9) || lv[0] !== 3'd1)
      $display("[TB] FAIL after_reset_drain: got v=%b d=%0h lvl=%0d, expected v=1 d=9 lvl=1", ov[0], od[0], lv[0]);
    else passed++;
    step(0, '0, '0, 0, 1);
    total++;
    if (the[0] !== 1'b1 || lv[0] !== 3'd0 || ov[0] !== 1'b0)
      $display("[TB] FAIL after_reset_end: got ended=%b lvl=%0d v=%b, expected 1/0/0", the[0], lv[0], ov[0]);
    else passed++;
  endtask

  task automatic test_random();
    logic v, te, rdy;
    logic [DW-1:0] b;
    logic [CW-1:0] c;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      b   = DW'($urandom);
      c   = CW'($urandom_range(0, 3));
      te  = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(v, b, c, te, rdy);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (ov[m] !== (mphase[m] == DRAIN_PH && mq[m].size() > 0) || the[m] !== (mphase[m] == DONE_PH) ||
            int'(lv[m]) !== mq[m].size() || get_ovf(m) !== movf[m] ||
            (ov[m] === 1'b1 && mq[m].size() > 0 && {oc[m], od[m]} !== mq[m][0]))
          $display("[TB] FAIL random inst%0d cyc%0d: got v=%b ended=%b lvl=%0d ovf=%0d entry=%0h, expected phase=%0d lvl=%0d ovf=%0d",
                   m, cyc, ov[m], the[m], lv[m], get_ovf(m), {oc[m], od[m]}, mphase[m], mq[m].size(), movf[m]);
        else passed++;
      end
      if (mphase[0] == DONE_PH && mphase[1] == DONE_PH) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_overflow();
    test_count_zero_stall();
    test_empty_end();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
